// File: rtl/rxd_pkg.sv
// Shared definitions for the IRDA receive frame controller: FSM states,
// frame layout and a small parity helper.
package rxd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } rxd_state_e;

    localparam int DATA_W     = 8;
    localparam int FRAME_W    = 10;
    localparam int STOP_BIT   = 9;
    localparam int PARITY_BIT = 8;
    localparam int DATA_MSB   = 7;

    // Even parity: the parity bit must equal the XOR of all data bits.
    function automatic logic evenParity(input logic [DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/rxd_parity.sv
// Combinational parity/framing checker for one received frame laid out as
// {stop, parity, data[7:0]}.
module rxd_parity
    import rxd_pkg::*;
(
    input  logic [FRAME_W-1:0] in_data,
    input  logic               par_check_i,
    output logic               par_err_o,
    output logic               frm_err_o
);

    assign par_err_o = par_check_i &
                       (in_data[PARITY_BIT] != evenParity(in_data[DATA_MSB:0]));
    assign frm_err_o = par_check_i & ~in_data[STOP_BIT];

endmodule

// File: rtl/rxd_frame_ctrl.sv
// Receive-side frame controller: synchronises rxd, finds the start bit,
// shifts in data/parity/stop and hands the byte over via a one-entry holding register.
module rxd_frame_ctrl
    import rxd_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              baud_tick,
    input  logic              rxd,
    input  logic              parity_check,
    input  logic              rd_ack,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              parity_error,
    output logic              framing_error,
    output logic              overrun_error,
    output logic              busy
);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OVERSAMPLE);

    logic               rxdMeta_q;
    logic               rxdSync_q;
    rxd_state_e         state_q;
    logic [CNT_W-1:0]   tickCnt_q;
    logic [CNT_W-1:0]   tickInc;
    logic [2:0]         bitCnt_q;
    logic [FRAME_W-1:0] frame_q;
    logic               busy_q;

    logic [DATA_W-1:0]  rxData_q,   rxData_d;
    logic               rxValid_q,  rxValid_d;
    logic               parErr_q,   parErr_d;
    logic               frmErr_q,   frmErr_d;
    logic               overrun_q,  overrun_d;

    logic               parErr;
    logic               frmErr;

    always_ff @(posedge clk) begin
        if (reset) begin
            rxdMeta_q <= 1'b1;
            rxdSync_q <= 1'b1;
        end else begin
            rxdMeta_q <= rxd;
            rxdSync_q <= rxdMeta_q;
        end
    end

    assign tickInc = tickCnt_q + CNT_W'(1);

    // Each sampling state counts ticks up to its threshold; the sample is
    // taken on the tick that brings the count to the threshold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            tickCnt_q <= '0;
            bitCnt_q  <= '0;
            frame_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (baud_tick && !rxdSync_q) begin
                        state_q   <= START;
                        tickCnt_q <= CNT_W'(1);
                        busy_q    <= 1'b1;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        if (tickInc == HALF_CNT) begin
                            tickCnt_q <= '0;
                            if (!rxdSync_q) begin
                                state_q  <= DATA;
                                bitCnt_q <= '0;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            tickCnt_q <= tickInc;
                        end
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (tickInc == FULL_CNT) begin
                            frame_q[bitCnt_q] <= rxdSync_q;
                            tickCnt_q         <= '0;
                            bitCnt_q          <= bitCnt_q + 3'd1;
                            if (bitCnt_q == 3'd7) begin
                                state_q <= PARITY;
                            end
                        end else begin
                            tickCnt_q <= tickInc;
                        end
                    end
                end
                PARITY: begin
                    if (baud_tick) begin
                        if (tickInc == FULL_CNT) begin
                            frame_q[PARITY_BIT] <= rxdSync_q;
                            tickCnt_q           <= '0;
                            state_q             <= STOP;
                        end else begin
                            tickCnt_q <= tickInc;
                        end
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        if (tickInc == FULL_CNT) begin
                            frame_q[STOP_BIT] <= rxdSync_q;
                            tickCnt_q         <= '0;
                            state_q           <= DONE;
                        end else begin
                            tickCnt_q <= tickInc;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    tickCnt_q <= '0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    rxd_parity u_parity (
        .in_data     (frame_q),
        .par_check_i (parity_check),
        .par_err_o   (parErr),
        .frm_err_o   (frmErr)
    );

    // An ack in the DONE cycle frees the slot, so the new frame replaces the
    // old one instead of being counted as an overrun.
    always_comb begin
        rxData_d  = rxData_q;
        rxValid_d = rxValid_q;
        parErr_d  = parErr_q;
        frmErr_d  = frmErr_q;
        overrun_d = overrun_q;
        if (state_q == DONE) begin
            if (!rxValid_q || rd_ack) begin
                rxData_d  = frame_q[DATA_MSB:0];
                parErr_d  = parErr;
                frmErr_d  = frmErr;
                rxValid_d = 1'b1;
                overrun_d = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rd_ack && rxValid_q) begin
            rxValid_d = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rxData_q  <= '0;
            rxValid_q <= 1'b0;
            parErr_q  <= 1'b0;
            frmErr_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            rxData_q  <= rxData_d;
            rxValid_q <= rxValid_d;
            parErr_q  <= parErr_d;
            frmErr_q  <= frmErr_d;
            overrun_q <= overrun_d;
        end
    end

    assign rx_data       = rxData_q;
    assign rx_valid      = rxValid_q;
    assign parity_error  = parErr_q;
    assign framing_error = frmErr_q;
    assign overrun_error = overrun_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_rxd_frame_ctrl.sv
// Self-checking bench for rxd_frame_ctrl: directed frames plus randomised
// frames, every cycle compared against a tick-counting reference model.
module tb_rxd_frame_ctrl;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       baud_tick;
    logic       rxd;
    logic       parity_check;
    logic       rd_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_error;
    logic       framing_error;
    logic       overrun_error;
    logic       busy;

    int checks = 0;
    int errors = 0;

    bit checkEn   = 1'b0;
    bit tickDense = 1'b1;
    bit ackInDone = 1'b0;

    bit       syncA = 1'b1;
    bit       syncB = 1'b1;
    bit       mActive = 1'b0;
    int       mN = 0;
    bit [9:0] mFrame = '0;
    bit       mDoneNext = 1'b0;
    bit [7:0] mData = '0;
    bit       mValid = 1'b0;
    bit       mPerr = 1'b0;
    bit       mFerr = 1'b0;
    bit       mOverrun = 1'b0;

    always #5 clk = ~clk;

    rxd_frame_ctrl #(.OVERSAMPLE(OS), .CNT_W(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .baud_tick     (baud_tick),
        .rxd           (rxd),
        .parity_check  (parity_check),
        .rd_ack        (rd_ack),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .busy          (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference receiver: counts ticks since the first low sample; the start
    // bit is confirmed at tick OS/2 and every later bit sits OS ticks further on.
    always @(posedge clk) begin
        bit lineS;
        int k;
        lineS = syncB;
        if (reset) begin
            syncA = 1'b1; syncB = 1'b1;
            mActive = 1'b0; mN = 0; mFrame = '0; mDoneNext = 1'b0;
            mData = '0; mValid = 1'b0; mPerr = 1'b0; mFerr = 1'b0; mOverrun = 1'b0;
        end else begin
            if (mDoneNext) begin
                mDoneNext = 1'b0;
                if (!mValid || rd_ack) begin
                    mData    = mFrame[7:0];
                    mPerr    = parity_check && (mFrame[8] != (^mFrame[7:0]));
                    mFerr    = parity_check && !mFrame[9];
                    mValid   = 1'b1;
                    mOverrun = 1'b0;
                end else begin
                    mOverrun = 1'b1;
                end
            end else begin
                if (rd_ack && mValid) begin
                    mValid   = 1'b0;
                    mOverrun = 1'b0;
                end
                if (baud_tick) begin
                    if (!mActive) begin
                        if (!lineS) begin
                            mActive = 1'b1;
                            mN = 1;
                        end
                    end else begin
                        mN++;
                        if (mN == OS / 2) begin
                            if (lineS) mActive = 1'b0;
                        end else if (mN > OS / 2 && (mN - OS / 2) % OS == 0) begin
                            k = (mN - OS / 2) / OS;
                            mFrame[k-1] = lineS;
                            if (k == 10) begin
                                mActive   = 1'b0;
                                mDoneNext = 1'b1;
                            end
                        end
                    end
                end
            end
            syncB = syncA;
            syncA = rxd;
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cyc_rx_valid", rx_valid, mValid);
            checkOutput("cyc_busy", busy, mActive || mDoneNext);
            checkOutput("cyc_rx_data", rx_data, mData);
            checkOutput("cyc_parity_error", parity_error, mPerr);
            checkOutput("cyc_framing_error", framing_error, mFerr);
            checkOutput("cyc_overrun_error", overrun_error, mOverrun);
        end
    end

    task automatic stepCycle();
        @(negedge clk);
        baud_tick = tickDense ? 1'b1 : ($urandom_range(0, 1) == 1);
        rd_ack    = ackInDone && mDoneNext;
    endtask

    task automatic waitTicks(input int n);
        int c = 0;
        while (c < n) begin
            stepCycle();
            if (baud_tick) c++;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic p, input logic s,
                                 input int gap);
        rxd = 1'b0;
        waitTicks(OS);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            waitTicks(OS);
        end
        rxd = p;
        waitTicks(OS);
        rxd = s;
        waitTicks(OS);
        rxd = 1'b1;
        waitTicks(gap);
    endtask

    task automatic pulseAck();
        @(negedge clk);
        baud_tick = 1'b0;
        rd_ack    = 1'b1;
        @(negedge clk);
        rd_ack    = 1'b0;
    endtask

    task automatic waitValid(input int budget);
        int c = 0;
        while (!rx_valid && c < budget) begin
            @(negedge clk);
            c++;
        end
        checkOutput("valid_seen", rx_valid, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        logic [7:0] d;
        logic       p;
        logic       s;

        reset = 1'b1; rxd = 1'b1; baud_tick = 1'b0; rd_ack = 1'b0; parity_check = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_rx_valid", rx_valid, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_rx_data", rx_data, 8'h00);
        checkOutput("reset_overrun", overrun_error, 1'b0);
        checkEn = 1'b1;
        reset   = 1'b0;
        waitTicks(4);

        $display("[TB] clean frame 0xA5");
        applyStimulus(8'hA5, 1'b0, 1'b1, 12);
        waitValid(50);
        checkOutput("a5_data", rx_data, 8'hA5);
        checkOutput("a5_perr", parity_error, 1'b0);
        checkOutput("a5_ferr", framing_error, 1'b0);
        pulseAck();
        checkOutput("a5_ack_valid", rx_valid, 1'b0);

        $display("[TB] parity error on 0x01");
        applyStimulus(8'h01, 1'b0, 1'b1, 12);
        waitValid(50);
        checkOutput("p01_perr", parity_error, 1'b1);
        pulseAck();
        parity_check = 1'b0;
        applyStimulus(8'h01, 1'b0, 1'b1, 12);
        waitValid(50);
        checkOutput("p01_nocheck_perr", parity_error, 1'b0);
        pulseAck();
        parity_check = 1'b1;

        $display("[TB] framing error on 0x3C");
        applyStimulus(8'h3C, 1'b0, 1'b0, 16);
        waitValid(50);
        checkOutput("f3c_data", rx_data, 8'h3C);
        checkOutput("f3c_ferr", framing_error, 1'b1);
        checkOutput("f3c_perr", parity_error, 1'b0);
        pulseAck();

        $display("[TB] false start then 0x55");
        rxd = 1'b0;
        waitTicks(3);
        rxd = 1'b1;
        waitTicks(20);
        checkOutput("false_valid", rx_valid, 1'b0);
        checkOutput("false_busy", busy, 1'b0);
        applyStimulus(8'h55, 1'b0, 1'b1, 12);
        waitValid(50);
        checkOutput("f55_data", rx_data, 8'h55);
        pulseAck();

        $display("[TB] overrun 0x11 then 0x22");
        applyStimulus(8'h11, 1'b0, 1'b1, 12);
        applyStimulus(8'h22, 1'b0, 1'b1, 12);
        checkOutput("ovr_data", rx_data, 8'h11);
        checkOutput("ovr_flag", overrun_error, 1'b1);
        checkOutput("ovr_valid", rx_valid, 1'b1);
        pulseAck();
        checkOutput("ovr_ack_valid", rx_valid, 1'b0);
        checkOutput("ovr_ack_flag", overrun_error, 1'b0);
        applyStimulus(8'h11, 1'b0, 1'b1, 12);
        ackInDone = 1'b1;
        applyStimulus(8'h22, 1'b0, 1'b1, 12);
        ackInDone = 1'b0;
        checkOutput("ackdone_data", rx_data, 8'h22);
        checkOutput("ackdone_valid", rx_valid, 1'b1);
        checkOutput("ackdone_overrun", overrun_error, 1'b0);

        $display("[TB] reset during data bit 4");
        d = 8'hF0;
        rxd = 1'b0;
        waitTicks(OS);
        for (int i = 0; i < 4; i++) begin
            rxd = d[i];
            waitTicks(OS);
        end
        rxd = d[4];
        waitTicks(OS / 2);
        @(negedge clk);
        baud_tick = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_valid", rx_valid, 1'b0);
        checkOutput("rst_data", rx_data, 8'h00);
        reset = 1'b0;
        rxd   = 1'b1;
        waitTicks(20);
        applyStimulus(8'hF0, 1'b0, 1'b1, 12);
        waitValid(50);
        checkOutput("f0_data", rx_data, 8'hF0);
        checkOutput("f0_perr", parity_error, 1'b0);
        checkOutput("f0_ferr", framing_error, 1'b0);
        pulseAck();

        $display("[TB] randomised frames");
        for (int n = 0; n < 14; n++) begin
            tickDense    = ($urandom_range(0, 1) == 1);
            ackInDone    = ($urandom_range(0, 3) == 0);
            parity_check = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            p = ($urandom_range(0, 2) == 0) ? ~(^d) : (^d);
            s = ($urandom_range(0, 3) != 0);
            applyStimulus(d, p, s, 12 + $urandom_range(0, 8));
            ackInDone = 1'b0;
            if ($urandom_range(0, 2) != 0) pulseAck();
        end
        tickDense = 1'b1;
        waitTicks(4);

        checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rxd_frame_ctrl.md
Name: rxd_frame_ctrl

Overview:
Receive-side frame controller for the IRDA RXD path. It oversamples the demodulated serial line and detects the start bit. It then shifts in 8 data bits, 1 parity bit and 1 stop bit, and assembles the 10-bit frame {stop, parity, data[7:0]}. It applies the parity/framing check to that frame and hands the byte plus error flags to the consumer through a single-entry holding register with a valid/ack handshake.

Parameters:
OVERSAMPLE, 16, baud_tick pulses per bit period (even, >=4)
CNT_W, 5, tick counter width (must hold OVERSAMPLE)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
baud_tick  input  1  one-cycle enable pulse at OVERSAMPLE x bit rate
rxd  input  1  serial data, idle high, LSB first
parity_check  input  1  1 = report parity/framing errors; 0 = errors forced 0
rd_ack  input  1  consumer pulse; pops holding register
rx_data  output  8  received byte (held)
rx_valid  output  1  holding register full
parity_error  output  1  parity error for held byte
framing_error  output  1  stop bit was 0 for held byte
overrun_error  output  1  a frame was dropped because the holding register was full
busy  output  1  FSM not in IDLE

Behaviour:
- One clock domain. reset is synchronous, active-high, and is the only reset.
- Reset values:
  - rx_data=0, rx_valid=0, parity_error=0, framing_error=0, overrun_error=0, busy=0
  - FSM=IDLE, tick_cnt=0, bit_cnt=0, frame=0
  - both rxd synchroniser flops=1
- rxd passes through a 2-flop synchroniser; all decisions use rxd_s.
- tick_cnt and bit_cnt advance only on cycles with baud_tick=1.
- FSM states and transitions:
  - IDLE: on baud_tick with rxd_s=0 -> START, tick_cnt=1.
  - START: on tick, tick_cnt++. At tick_cnt==OVERSAMPLE/2, sample rxd_s: 0 -> DATA with tick_cnt=0, bit_cnt=0; 1 -> false start, go to IDLE with no output.
  - DATA: at tick_cnt==OVERSAMPLE, frame[bit_cnt]=rxd_s, tick_cnt=0, bit_cnt++. After bit 7 -> PARITY.
  - PARITY: at tick_cnt==OVERSAMPLE, frame[8]=rxd_s -> STOP.
  - STOP: at tick_cnt==OVERSAMPLE, frame[9]=rxd_s -> DONE.
  - DONE: exactly one clk cycle, independent of baud_tick. Load the holding register and go to IDLE.
- Line idle during the second half of the stop bit is normal. A new start may be detected on the first tick after returning to IDLE.
- Frame check, combinational on frame:
  - par_err = parity_check & (frame[8] != ^frame[7:0]) (even parity)
  - frm_err = parity_check & ~frame[9]
- Latency: if the edge with baud_tick samples the stop bit at edge N, DONE is active after N and rx_valid/rx_data/errors are visible after edge N+1.
- Holding register:
  - In DONE with rx_valid=0, or with rx_valid=1 and rd_ack=1 in the same cycle: load rx_data=frame[7:0], parity_error, framing_error; rx_valid=1.
  - In DONE with rx_valid=1 and rd_ack=0: drop the new frame, keep the old contents, set overrun_error=1 (sticky).
  - rd_ack with rx_valid=1 outside DONE: rx_valid=0, overrun_error=0. rx_data and the error flags hold their last values.
  - rd_ack with rx_valid=0 is ignored.
- parity_check is sampled in DONE only. Changing it mid-frame is legal.
- Reset mid-frame: return to IDLE next cycle, partial frame discarded, all outputs to reset values.
- baud_tick held high continuously is legal; every cycle counts as a tick.

Decomposition:
- Shared package rxd_pkg holds:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP, DONE)
  - frame bit indices: STOP_BIT=9, PARITY_BIT=8, DATA_MSB=7
  - DATA_W=8, FRAME_W=10
- Sub-module: rxd_parity, the team's existing combinational parity/framing checker, instantiated on frame with parity_check. Its in_data[9]=stop, [8]=parity, [7:0]=data layout matches frame exactly.
- The synchroniser stays inline.

Test Plan:
- Frame 0xA5, parity bit 0, stop 1, parity_check=1 -> rx_data=0xA5, rx_valid=1 two edges after the stop sample, parity_error=0, framing_error=0.
- Frame 0x01 with parity bit 0 -> parity_error=1. Same frame with parity_check=0 -> parity_error=0.
- Frame 0x3C, parity 0, stop bit 0 -> framing_error=1, rx_data=0x3C, rx_valid=1.
- rxd low for only 3 ticks then high -> no rx_valid, busy returns to 0 by tick OVERSAMPLE/2, next valid frame 0x55 received correctly.
- Two frames 0x11 then 0x22 with no rd_ack -> rx_data=0x11, overrun_error=1. Then rd_ack -> rx_valid=0, overrun_error=0. Repeat with rd_ack in the DONE cycle -> rx_data=0x22, no overrun.
- reset asserted during DATA bit 4 -> all outputs 0 and busy=0 next cycle, following frame 0xF0 received intact.
